// File: rtl/treeval_param.sv
// Parametrised tree evaluator: sweeps the node buffer from N-1 down to 1 and
// commits each sibling group's best weighted reward to its parent. Optional macro: TREEVAL_SAT_EN.
//
// state  | meaning
// IDLE   | waiting for start, sideband writes and config loads accepted
// CLEAR  | zero per-action accumulators and valid flags
// ACCUM  | accumulate one node into its action slot
// COMMIT | write the group maximum into the parent
// DONE   | one-cycle completion pulse
module treeval_param #(
  parameter int MAX_NODES    = 1024,
  parameter int NUM_ACTIONS  = 8,
  parameter int W_REWARD     = 12,
  parameter int W_WEIGHT     = 8,
  parameter int WEIGHT_SHIFT = 7,
  parameter int W_ADDR       = $clog2(MAX_NODES),
  parameter int W_ACTION     = $clog2(NUM_ACTIONS),
  parameter int W_ACC        = W_REWARD + W_WEIGHT + W_ADDR,
  parameter int W_DATA       = (W_REWARD >= W_WEIGHT)
                               ? ((W_REWARD >= W_ADDR) ? W_REWARD : W_ADDR)
                               : ((W_WEIGHT >= W_ADDR) ? W_WEIGHT : W_ADDR)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [1:0]                 wr_field,
  input  logic [W_ADDR-1:0]          wr_addr,
  input  logic [W_DATA-1:0]          wr_data,
  input  logic                       cfg_en,
  input  logic [W_ADDR:0]            cfg_nodes,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       wr_err,
  output logic signed [W_REWARD-1:0] exp,
  output logic [W_ACTION-1:0]        act
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_COMMIT, S_DONE} state_t;

  state_t state, state_nx;

  logic [W_ADDR-1:0]          parent_mem [MAX_NODES];
  logic [W_ACTION-1:0]        action_mem [MAX_NODES];
  logic signed [W_REWARD-1:0] reward_mem [MAX_NODES];
  logic [W_WEIGHT-1:0]        weight_mem [MAX_NODES];

  logic [W_ADDR:0]         n_nodes;
  logic [W_ADDR-1:0]       idx;
  logic signed [W_ACC-1:0] acc [NUM_ACTIONS];
  logic [NUM_ACTIONS-1:0]  valid;

  logic                       last_in_group;
  logic signed [W_ACC-1:0]    r_ext, w_ext, prod;
  logic signed [W_ACC-1:0]    best;
  logic [W_ACTION-1:0]        best_idx;
  logic                       found;
  logic signed [W_REWARD-1:0] commit_val;
  logic [W_ADDR-1:0]          cur_parent;
  logic [W_ACTION-1:0]        cur_action;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign exp  = reward_mem[0];
  assign act  = action_mem[0];

  assign cur_parent    = parent_mem[idx];
  assign cur_action    = action_mem[idx];
  assign last_in_group = (idx == W_ADDR'(1)) || (parent_mem[idx - W_ADDR'(1)] != cur_parent);

  // Reward is signed, weight unsigned; widen both before multiplying.
  assign r_ext = W_ACC'(reward_mem[idx]);
  assign w_ext = W_ACC'(weight_mem[idx]);
  assign prod  = r_ext * w_ext;

  // Ascending scan with strict compare keeps the lowest index on ties.
  always_comb begin
    best     = '0;
    best_idx = '0;
    found    = 1'b0;
    for (int k = 0; k < NUM_ACTIONS; k++) begin
      if (valid[k] && (!found || acc[k] > best)) begin
        best     = acc[k];
        best_idx = W_ACTION'(k);
        found    = 1'b1;
      end
    end
  end

`ifdef TREEVAL_SAT_EN
  localparam logic signed [W_ACC-1:0] R_MAX = W_ACC'((64'sd1 <<< (W_REWARD - 1)) - 64'sd1);
  localparam logic signed [W_ACC-1:0] R_MIN = ~R_MAX;
  logic signed [W_ACC-1:0] best_sh;
  assign best_sh = best >>> WEIGHT_SHIFT;
  always_comb begin
    if (best_sh > R_MAX)      commit_val = R_MAX[W_REWARD-1:0];
    else if (best_sh < R_MIN) commit_val = R_MIN[W_REWARD-1:0];
    else                      commit_val = best_sh[W_REWARD-1:0];
  end
`else
  // Low bits of the arithmetic shift: two's-complement wrap.
  assign commit_val = best[WEIGHT_SHIFT +: W_REWARD];
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = (n_nodes >= (W_ADDR+1)'(2)) ? S_CLEAR : S_DONE;
      S_CLEAR:  state_nx = S_ACCUM;
      S_ACCUM:  if (last_in_group) state_nx = S_COMMIT;
      S_COMMIT: state_nx = (idx == W_ADDR'(1)) ? S_DONE : S_CLEAR;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Only node 0 is cleared on reset so committed interior rewards survive.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err        <= 1'b0;
      n_nodes       <= (W_ADDR+1)'(MAX_NODES);
      idx           <= '0;
      valid         <= '0;
      reward_mem[0] <= '0;
      action_mem[0] <= '0;
      for (int k = 0; k < NUM_ACTIONS; k++) acc[k] <= '0;
    end else begin
      wr_err <= busy && (wr_en || cfg_en);
      if (!busy) begin
        if (cfg_en) n_nodes <= cfg_nodes;
        if (wr_en) begin
          case (wr_field)
            2'd0:    parent_mem[wr_addr] <= wr_data[W_ADDR-1:0];
            2'd1:    action_mem[wr_addr] <= wr_data[W_ACTION-1:0];
            2'd2:    reward_mem[wr_addr] <= wr_data[W_REWARD-1:0];
            default: weight_mem[wr_addr] <= wr_data[W_WEIGHT-1:0];
          endcase
        end
      end
      case (state)
        S_IDLE:  if (start) idx <= W_ADDR'(n_nodes - (W_ADDR+1)'(1));
        S_CLEAR: begin
          valid <= '0;
          for (int k = 0; k < NUM_ACTIONS; k++) acc[k] <= '0;
        end
        S_ACCUM: begin
          acc[cur_action]   <= acc[cur_action] + prod;
          valid[cur_action] <= 1'b1;
          if (!last_in_group) idx <= idx - W_ADDR'(1);
        end
        S_COMMIT: begin
          reward_mem[cur_parent] <= commit_val;
          if (cur_parent == '0) action_mem[0] <= best_idx;
          if (idx != W_ADDR'(1)) idx <= idx - W_ADDR'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_treeval_param.sv
// Directed bench for treeval_param: hand-computed trees, latency, handshake and reset behaviour.
module tb_treeval_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, cfg_en = 1'b0, start = 1'b0;
  logic [1:0]  wr_field = '0;
  logic [9:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic [10:0] cfg_nodes = '0;
  logic        busy, done, wr_err;
  logic [11:0] exp_w;
  logic [2:0]  act_w;

  int n_chk = 0;
  int n_fail = 0;
  int lat, nd;

`ifdef TREEVAL_SAT_EN
  localparam logic [11:0] OVF_EXP = 12'd2047;
`else
  localparam logic [11:0] OVF_EXP = 12'hFFE;
`endif

  treeval_param dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_field(wr_field), .wr_addr(wr_addr),
    .wr_data(wr_data), .cfg_en(cfg_en), .cfg_nodes(cfg_nodes), .start(start),
    .busy(busy), .done(done), .wr_err(wr_err), .exp(exp_w), .act(act_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [1:0] f, input int a, input int d);
    @(negedge clk);
    wr_en = 1'b1; wr_field = f; wr_addr = 10'(a); wr_data = 12'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic node(input int a, input int p, input int ac, input int r, input int w);
    wr(2'd0, a, p);
    wr(2'd1, a, ac);
    wr(2'd2, a, r);
    wr(2'd3, a, w);
  endtask

  task automatic cfg(input int n);
    @(negedge clk);
    cfg_en = 1'b1; cfg_nodes = 11'(n);
    @(negedge clk);
    cfg_en = 1'b0;
  endtask

  // lat = cycles from the start-sampling edge to the cycle showing done.
  task automatic run(output int l, output int ndn);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    l = 1;
    while (!done && l < 3000) begin
      @(negedge clk);
      l++;
    end
    check("done_seen", 32'(done), 32'd1);
    ndn = int'(done);
    repeat (3) begin
      @(negedge clk);
      ndn += int'(done);
    end
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_exp", 32'(exp_w), 32'd0);
    check("rst_act", 32'(act_w), 32'd0);
    rst = 1'b0;

    // Two-level tree: node1 takes 50 from node3, root picks action 0 (50 vs 20).
    cfg(4);
    node(1, 0, 0, 0, 128);
    node(2, 0, 1, 20, 128);
    node(3, 1, 0, 50, 128);
    check("idle_wr_err", 32'(wr_err), 32'd0);
    run(lat, nd);
    check("s1_lat", 32'(lat), 32'd8);
    check("s1_ndone", 32'(nd), 32'd1);
    check("s1_exp", 32'(exp_w), 32'd50);
    check("s1_act", 32'(act_w), 32'd0);

    // Negative rewards.
    cfg(3);
    node(1, 0, 1, -30, 128);
    node(2, 0, 0, -100, 128);
    run(lat, nd);
    check("s2_lat", 32'(lat), 32'd5);
    check("s2_exp", 32'(exp_w), 32'h0FE2);
    check("s2_act", 32'(act_w), 32'd1);

    // N<2 goes straight to DONE, root untouched.
    cfg(1);
    run(lat, nd);
    check("n1_lat", 32'(lat), 32'd1);
    check("n1_ndone", 32'(nd), 32'd1);
    check("n1_exp", 32'(exp_w), 32'h0FE2);
    check("n1_act", 32'(act_w), 32'd1);

    // Tie goes to the lower action index.
    cfg(3);
    node(1, 0, 1, 40, 128);
    node(2, 0, 0, 40, 128);
    run(lat, nd);
    check("tie_exp", 32'(exp_w), 32'd40);
    check("tie_act", 32'(act_w), 32'd0);

    // -3*64 = -192 >>> 7 = -2 (floor), beats -100.
    node(1, 0, 1, -3, 64);
    node(2, 0, 0, -100, 128);
    run(lat, nd);
    check("floor_exp", 32'(exp_w), 32'h0FFE);
    check("floor_act", 32'(act_w), 32'd1);

    // Same slot: 100*64 - 8*128 = 5376 >>> 7 = 42.
    node(1, 0, 0, -8, 128);
    node(2, 0, 0, 100, 64);
    run(lat, nd);
    check("wsum_exp", 32'(exp_w), 32'd42);
    check("wsum_act", 32'(act_w), 32'd0);

    // 2*2047 overflows the reward width.
    node(1, 0, 0, 2047, 128);
    node(2, 0, 0, 2047, 128);
    run(lat, nd);
    check("ovf_exp", 32'(exp_w), 32'(OVF_EXP));
    check("ovf_act", 32'(act_w), 32'd0);

    // Writes, config and a second start while busy are all dropped.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b_busy", 32'(busy), 32'd1);
    wr_en = 1'b1; wr_field = 2'd2; wr_addr = 10'd1; wr_data = 12'h800;
    cfg_en = 1'b1; cfg_nodes = 11'd1; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; cfg_en = 1'b0; start = 1'b0;
    check("b_wr_err_hi", 32'(wr_err), 32'd1);
    @(negedge clk);
    check("b_wr_err_lo", 32'(wr_err), 32'd0);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("b_done_seen", 32'(done), 32'd1);
    nd = int'(done);
    repeat (4) begin
      @(negedge clk);
      nd += int'(done);
    end
    check("b_ndone", 32'(nd), 32'd1);
    check("b_idle", 32'(busy), 32'd0);
    check("b_exp", 32'(exp_w), 32'(OVF_EXP));
    run(lat, nd);
    check("b_rerun_lat", 32'(lat), 32'd5);
    check("b_rerun_exp", 32'(exp_w), 32'(OVF_EXP));

    // Reset during ACCUM clears the root and aborts the sweep.
    cfg(4);
    node(1, 0, 0, 0, 128);
    node(2, 0, 1, 20, 128);
    node(3, 1, 0, 50, 128);
    run(lat, nd);
    check("r_pre_exp", 32'(exp_w), 32'd50);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("r_busy_accum", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("r_busy", 32'(busy), 32'd0);
    check("r_done", 32'(done), 32'd0);
    check("r_exp", 32'(exp_w), 32'd0);
    rst = 1'b0;
    cfg(4);
    run(lat, nd);
    check("r_lat", 32'(lat), 32'd8);
    check("r_ndone", 32'(nd), 32'd1);
    check("r_exp_rerun", 32'(exp_w), 32'd50);
    check("r_act_rerun", 32'(act_w), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
